// File: rtl/i2s_rx.sv
// i2s_rx -- Philips-format I2S receiver.
// The asynchronous BCK/LRCK/DATA pins are synchronized into clk_sys.
// Each channel slot is deserialized MSB first. Completed left/right
// words are presented as a coherent pair.
//
// Output timing: sample_valid is a one-cycle strobe with no back-pressure.
// In the strobe cycle, right holds the newest word and left holds the word
// from the same frame. Both stay stable until the next word of their
// channel completes.
//
// Latency: an i2s_bck rise on the pin is first sampled by one clk_sys edge.
// All state it causes lands on the SYNC_STAGES+1'th edge counted from that
// first sampling edge, inclusive (3 edges at the default depth).
module i2s_rx #(
   parameter int AUDIO_DW       = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                i2s_bck,
   input  logic                i2s_lrck,
   input  logic                i2s_data,
   output logic [AUDIO_DW-1:0] left,
   output logic [AUDIO_DW-1:0] right,
   output logic                sample_valid,
   output logic                locked,
   output logic                short_err
);

   localparam int CW = $clog2(AUDIO_DW + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] CNT_FULL = CW'(AUDIO_DW);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);

   // IDLE: waiting for the first BCK rise to learn the current LRCK level.
   // SEEK: framing unknown; the word in progress is partial and is dropped.
   // LOCKED: every LRCK transition delivers a complete word.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEEK   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Synchronizer chains; bit 0 faces the pin.
   logic [SYNC_STAGES-1:0] bck_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   bck_prev;

   logic bck_s;
   logic lrck_s;
   logic data_s;
   logic bck_rise;

   // Word tracking registers.
   logic [AUDIO_DW-1:0] sr;
   logic [CW-1:0]       cnt;
   logic                cur_ch;
   logic                prev_lrck;

   // BCK activity watchdog.
   logic [TW-1:0] idle_cnt;
   logic          timeout;

   // Next-state values produced by the FSM process.
   logic [AUDIO_DW-1:0] sr_nxt;
   logic [CW-1:0]       cnt_nxt;
   logic                cur_ch_nxt;
   logic                prev_lrck_nxt;
   logic [AUDIO_DW-1:0] left_nxt;
   logic [AUDIO_DW-1:0] right_nxt;
   logic                sample_valid_nxt;
   logic                short_err_nxt;
   logic                locked_nxt;

   // Word-assembly helpers.
   logic                take_bit;
   logic [AUDIO_DW-1:0] sr_shift;
   logic [CW-1:0]       cnt_shift;
   logic [CW-1:0]       pad_amt;
   logic [AUDIO_DW-1:0] word;
   logic                transition;

   // Bring the three serial pins into clk_sys and remember the last synchronized BCK.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bck_sync  <= '0;
         lrck_sync <= '0;
         data_sync <= '0;
         bck_prev  <= 1'b0;
      end else begin
         bck_sync  <= {bck_sync[SYNC_STAGES-2:0], i2s_bck};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i2s_data};
         bck_prev  <= bck_s;
      end
   end

   assign bck_s    = bck_sync[SYNC_STAGES-1];
   assign lrck_s   = lrck_sync[SYNC_STAGES-1];
   assign data_s   = data_sync[SYNC_STAGES-1];
   assign bck_rise = bck_s & ~bck_prev;

   // Count clk_sys cycles since the last BCK rise.
   // The count saturates, so the timeout fires only once per stall.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (bck_rise) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TO_MAX) begin
         idle_cnt <= idle_cnt + TO_ONE;
      end
   end

   assign timeout = !bck_rise && (idle_cnt == TO_LAST);

   // Shift the current bit in, unless the word is already full.
   // Extra bits in a long slot are dropped, which truncates the slot.
   // A short word is left-aligned, with zero padding in the LSBs.
   always_comb begin
      take_bit   = bck_rise && (cnt < CNT_FULL);
      sr_shift   = take_bit ? {sr[AUDIO_DW-2:0], data_s} : sr;
      cnt_shift  = take_bit ? (cnt + CNT_ONE) : cnt;
      pad_amt    = CNT_FULL - cnt_shift;
      word       = sr_shift << pad_amt;
      transition = bck_rise && (lrck_s != prev_lrck);
   end

   // FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath decisions for each BCK rise or timeout.
   always_comb begin
      state_nxt        = state;
      sr_nxt           = sr;
      cnt_nxt          = cnt;
      cur_ch_nxt       = cur_ch;
      prev_lrck_nxt    = prev_lrck;
      left_nxt         = left;
      right_nxt        = right;
      sample_valid_nxt = 1'b0;
      short_err_nxt    = 1'b0;
      locked_nxt       = locked;

      if (timeout) begin
         // A stalled bit clock loses framing. The last samples are kept.
         state_nxt  = ST_IDLE;
         locked_nxt = 1'b0;
         sr_nxt     = '0;
         cnt_nxt    = '0;
      end else if (bck_rise) begin
         prev_lrck_nxt = lrck_s;
         case (state)
            ST_IDLE: begin
               state_nxt = ST_SEEK;
            end
            ST_SEEK, ST_LOCKED: begin
               sr_nxt  = sr_shift;
               cnt_nxt = cnt_shift;
               if (transition) begin
                  // The bit on this rise was the LSB of the word that just ended.
                  sr_nxt     = '0;
                  cnt_nxt    = '0;
                  cur_ch_nxt = lrck_s;
                  if (state == ST_SEEK) begin
                     state_nxt  = ST_LOCKED;
                     locked_nxt = 1'b1;
                  end else begin
                     if (cur_ch) begin
                        right_nxt        = word;
                        sample_valid_nxt = 1'b1;
                     end else begin
                        left_nxt = word;
                     end
                     short_err_nxt = (cnt_shift < CNT_FULL);
                  end
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Register the word tracking state and the outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sr           <= '0;
         cnt          <= '0;
         cur_ch       <= 1'b0;
         prev_lrck    <= 1'b0;
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         short_err    <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sr           <= sr_nxt;
         cnt          <= cnt_nxt;
         cur_ch       <= cur_ch_nxt;
         prev_lrck    <= prev_lrck_nxt;
         left         <= left_nxt;
         right        <= right_nxt;
         sample_valid <= sample_valid_nxt;
         short_err    <= short_err_nxt;
         locked       <= locked_nxt;
      end
   end

endmodule
